// File: rtl/ram8_arbiter_pkg.sv
// rtl/ram8_arbiter_pkg.sv - shared widths and FSM state encoding for the two-port RAM8 arbiter
package ram8_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/ram8.sv
// rtl/ram8.sv - 16-bit x 8 word RAM, synchronous write, combinational read
module ram8
  import ram8_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  // Contents are deliberately left out of reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (load) begin
      mem_q[address] <= in;
    end
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram8_arbiter.sv
// rtl/ram8_arbiter.sv - round-robin two-port arbiter in front of a single ram8
module ram8_arbiter
  import ram8_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  state_e              state_q;
  logic                last_served_q;
  logic                winner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ack0_q;
  logic                ack1_q;

  logic                grant_d;
  logic                ram_load;
  logic [DATA_W-1:0]   ram_out;

  // Tie goes to the port that was not granted last; otherwise the sole requester.
  always_comb begin
    grant_d = 1'b0;
    if (req0 && req1) begin
      grant_d = ~last_served_q;
    end else begin
      grant_d = req1;
    end
  end

  // Gating with reset lets a reset in SERVE abort the write on that same edge.
  assign ram_load = (state_q == SERVE) && we_q && !reset;

  ram8 u_ram (
    .clk     (clk),
    .in      (wdata_q),
    .load    (ram_load),
    .address (addr_q),
    .out     (ram_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      winner_q      <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            winner_q      <= grant_d;
            last_served_q <= grant_d;
            we_q          <= grant_d ? we1    : we0;
            addr_q        <= grant_d ? addr1  : addr0;
            wdata_q       <= grant_d ? wdata1 : wdata0;
            state_q       <= SERVE;
          end
        end
        SERVE: begin
          rdata_q <= we_q ? wdata_q : ram_out;
          ack0_q  <= ~winner_q;
          ack1_q  <= winner_q;
          state_q <= ACK;
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule
